// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address and fills IF/ID with branch, jump, stall and halt handling.
// Optional fetch counter output enabled by defining IFU_PERF_CNT_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  // state | meaning
  // BOOT  | first cycle after reset, pc at RESET_PC, IF/ID bubble
  // RUN   | normal fetch with redirect/stall handling
  // HALT  | halt word seen, pc frozen, IF/ID bubble until a branch redirect
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pc_plus4;
  logic [31:0] if_pc_nx, if_pc4_nx, if_inst_nx;
  logic        if_valid_nx;
  logic        load;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    if_pc_nx    = if_pc;
    if_pc4_nx   = if_pc4;
    if_inst_nx  = if_inst;
    if_valid_nx = if_valid;
    load        = 1'b0;
    case (state)
      BOOT: begin
        state_nx    = RUN;
        if_inst_nx  = 32'h0;
        if_valid_nx = 1'b0;
      end
      RUN: begin
        // Branch outranks jump and stall: it belongs to the older instruction.
        if (br_taken) begin
          pc_nx       = br_target & 32'hFFFF_FFFC;
          if_inst_nx  = 32'h0;
          if_valid_nx = 1'b0;
        end else if (jump) begin
          pc_nx       = {if_pc4[31:28], jump_index, 2'b00};
          if_inst_nx  = 32'h0;
          if_valid_nx = 1'b0;
        end else if (!stall) begin
          load        = 1'b1;
          if_pc_nx    = pc;
          if_pc4_nx   = pc_plus4;
          if_inst_nx  = imem_inst;
          if_valid_nx = 1'b1;
          pc_nx       = pc_plus4;
          if (imem_inst == HALT_INST) state_nx = HALT;
        end
      end
      HALT: begin
        if_inst_nx  = 32'h0;
        if_valid_nx = 1'b0;
        if (br_taken) begin
          pc_nx    = br_target & 32'hFFFF_FFFC;
          state_nx = RUN;
        end
      end
      default: begin
        state_nx    = BOOT;
        if_inst_nx  = 32'h0;
        if_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      if_pc    <= 32'h0;
      if_pc4   <= 32'h0;
      if_inst  <= 32'h0;
      if_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      if_pc    <= if_pc_nx;
      if_pc4   <= if_pc4_nx;
      if_inst  <= if_inst_nx;
      if_valid <= if_valid_nx;
      halted   <= (state_nx == HALT);
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fetch_cnt <= 32'h0;
    else if (load) fetch_cnt <= fetch_cnt + 32'd1;
  end
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule
